cpu_ctrl: RTL and testbench

Run-control and program-load controller for the 4-bit accumulator CPU core.
- Gates the core through a clock enable, holds it in reset on demand, and writes 8-bit instruction words into the 16-entry program memory.
- Provides run, halt, N-cycle single-step, a PC breakpoint and a cycle counter.
- Sits between a host command port (debug UART/JTAG bridge) and the core's clock-enable, reset and program-memory write port.

---
 rtl/cpu_ctrl_if.sv | 20 ++
 rtl/cpu_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_cpu_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_if.sv
// cpu_ctrl_if: host command port of the CPU run-control block.
//   master : host side (drives cmd_valid/op/addr/data, sees ready/err)
//   slave  : controller side
//   cmd_op : 0 NOP, 1 WRITE, 2 RUN, 3 HALT, 4 STEP, 5 SETBP, 6 CLRBP, 7 RSTCORE
interface cpu_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int CODE_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [CODE_W-1:0] cmd_data;
  logic              cmd_err;

  modport master (output cmd_valid, cmd_op, cmd_addr, cmd_data,
                  input  cmd_ready, cmd_err);
  modport slave  (input  cmd_valid, cmd_op, cmd_addr, cmd_data,
                  output cmd_ready, cmd_err);
endinterface

// File: rtl/cpu_ctrl.sv
// cpu_ctrl: run-control / program-load controller for the 4-bit accumulator core.
//   clk, rst  : single clock, synchronous active-high reset
//   cmd       : host command port (cpu_ctrl_if.slave)
//   core_pc   : current core PC (breakpoint compare)
//   core_en   : core clock enable, core_rst : core reset
//   pm_we/pm_addr/pm_wdata : program-memory write port
//   halted, bp_hit (sticky), cyc_cnt (saturating count of core_en cycles)
// Build option: define CPU_CTRL_BP_EN to implement the PC breakpoint; without
// it SETBP/CLRBP are silent no-ops and bp_hit is tied low.
module cpu_ctrl #(
  parameter int ADDR_W = 4,
  parameter int CODE_W = 8,
  parameter int CYC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  cpu_ctrl_if.slave         cmd,
  input  logic [ADDR_W-1:0] core_pc,
  output logic              core_en,
  output logic              core_rst,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [CODE_W-1:0] pm_wdata,
  output logic              halted,
  output logic              bp_hit,
  output logic [CYC_W-1:0]  cyc_cnt
);
  typedef enum logic [1:0] {S_RSTC, S_HALT, S_RUN, S_STEP} state_e;

  localparam logic [2:0] OP_WRITE = 3'd1, OP_RUN = 3'd2, OP_HALT = 3'd3,
                         OP_STEP = 3'd4, OP_SETBP = 3'd5, OP_CLRBP = 3'd6,
                         OP_RSTCORE = 3'd7;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] step_q, step_d;
  logic              pm_we_q, pm_we_d;
  logic [ADDR_W-1:0] pm_addr_q, pm_addr_d;
  logic [CODE_W-1:0] pm_wdata_q, pm_wdata_d;
  logic              err_q, err_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              accept, match;

`ifdef CPU_CTRL_BP_EN
  logic              bp_valid_q, bp_valid_d;
  logic [ADDR_W-1:0] bp_addr_q, bp_addr_d;
  logic              skip_q, skip_d;
  logic              bp_hit_q, bp_hit_d;

  // skip lets a RUN resumed at the breakpoint PC execute that instruction.
  assign match  = bp_valid_q && (core_pc == bp_addr_q) && (state_q == S_RUN) && !skip_q;
  assign bp_hit = bp_hit_q;
`else
  logic unused_pc;
  assign unused_pc = ^core_pc;
  assign match     = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  assign cmd.cmd_ready = (state_q == S_HALT) || (state_q == S_RUN);
  assign cmd.cmd_err   = err_q;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  // Enable depends only on registered state and core_pc, never on cmd_*.
  assign core_en  = ((state_q == S_RUN) && !match) || (state_q == S_STEP);
  assign core_rst = (state_q == S_RSTC);
  assign halted   = (state_q == S_HALT);
  assign pm_we    = pm_we_q;
  assign pm_addr  = pm_addr_q;
  assign pm_wdata = pm_wdata_q;
  assign cyc_cnt  = cyc_q;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    pm_we_d    = 1'b0;
    pm_addr_d  = pm_addr_q;
    pm_wdata_d = pm_wdata_q;
    err_d      = 1'b0;
    cyc_d      = (core_en && (cyc_q != {CYC_W{1'b1}})) ? cyc_q + 1'b1 : cyc_q;
`ifdef CPU_CTRL_BP_EN
    bp_valid_d = bp_valid_q;
    bp_addr_d  = bp_addr_q;
    skip_d     = skip_q;
    bp_hit_d   = bp_hit_q;
`endif

    // autonomous state behaviour
    case (state_q)
      S_RSTC: begin
        state_d = S_HALT;
        cyc_d   = '0;
`ifdef CPU_CTRL_BP_EN
        bp_hit_d = 1'b0;
`endif
      end
      S_STEP: begin
        step_d = step_q - 1'b1;
        if (step_q <= CODE_W'(1)) state_d = S_HALT;
      end
      S_RUN: begin
`ifdef CPU_CTRL_BP_EN
        skip_d = 1'b0;
        if (match) begin
          state_d  = S_HALT;
          bp_hit_d = 1'b1;
        end
`endif
      end
      default: ;
    endcase

    // host commands (only HALT/RUN accept)
    if (accept) begin
      case (cmd.cmd_op)
        OP_WRITE: begin
          if (state_q == S_HALT) begin
            pm_we_d    = 1'b1;
            pm_addr_d  = cmd.cmd_addr;
            pm_wdata_d = cmd.cmd_data;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_RUN: begin
          if (state_q == S_HALT) begin
            state_d = S_RUN;
`ifdef CPU_CTRL_BP_EN
            skip_d = 1'b1;
`endif
          end
        end
        // HALT together with a breakpoint match still lands in HALT with bp_hit.
        OP_HALT: if (state_q == S_RUN) state_d = S_HALT;
        OP_STEP: begin
          if (state_q == S_HALT) begin
            state_d = S_STEP;
            step_d  = (cmd.cmd_data == '0) ? CODE_W'(1) : cmd.cmd_data;
          end else begin
            err_d = 1'b1;
          end
        end
`ifdef CPU_CTRL_BP_EN
        OP_SETBP: begin
          bp_addr_d  = cmd.cmd_addr;
          bp_valid_d = 1'b1;
        end
        OP_CLRBP: bp_valid_d = 1'b0;
`else
        OP_SETBP, OP_CLRBP: ;
`endif
        OP_RSTCORE: state_d = S_RSTC;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RSTC;
      step_q     <= '0;
      pm_we_q    <= 1'b0;
      pm_addr_q  <= '0;
      pm_wdata_q <= '0;
      err_q      <= 1'b0;
      cyc_q      <= '0;
`ifdef CPU_CTRL_BP_EN
      bp_valid_q <= 1'b0;
      bp_addr_q  <= '0;
      skip_q     <= 1'b0;
      bp_hit_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      pm_we_q    <= pm_we_d;
      pm_addr_q  <= pm_addr_d;
      pm_wdata_q <= pm_wdata_d;
      err_q      <= err_d;
      cyc_q      <= cyc_d;
`ifdef CPU_CTRL_BP_EN
      bp_valid_q <= bp_valid_d;
      bp_addr_q  <= bp_addr_d;
      skip_q     <= skip_d;
      bp_hit_q   <= bp_hit_d;
`endif
    end
  end
endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed bench for cpu_ctrl: reset, program load, step, breakpoint (or its
// absence), core reset, and counter saturation on a narrow-counter instance.
module tb_cpu_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_ctrl_if #(.ADDR_W(4), .CODE_W(8)) hif ();
  cpu_ctrl_if #(.ADDR_W(4), .CODE_W(8)) hif2 ();

  logic [3:0]  pc = '0;
  logic        core_en, core_rst, pm_we, halted, bp_hit;
  logic [3:0]  pm_addr;
  logic [7:0]  pm_wdata;
  logic [15:0] cyc_cnt;

  logic        core_en2, core_rst2, pm_we2, halted2, bp_hit2;
  logic [3:0]  pm_addr2;
  logic [7:0]  pm_wdata2;
  logic [3:0]  cyc_cnt2;
  logic [3:0]  pc2 = '0;

  cpu_ctrl #(.ADDR_W(4), .CODE_W(8), .CYC_W(16)) dut (
    .clk(clk), .rst(rst), .cmd(hif.slave), .core_pc(pc),
    .core_en(core_en), .core_rst(core_rst), .pm_we(pm_we), .pm_addr(pm_addr),
    .pm_wdata(pm_wdata), .halted(halted), .bp_hit(bp_hit), .cyc_cnt(cyc_cnt));

  cpu_ctrl #(.ADDR_W(4), .CODE_W(8), .CYC_W(4)) dut4 (
    .clk(clk), .rst(rst), .cmd(hif2.slave), .core_pc(pc2),
    .core_en(core_en2), .core_rst(core_rst2), .pm_we(pm_we2), .pm_addr(pm_addr2),
    .pm_wdata(pm_wdata2), .halted(halted2), .bp_hit(bp_hit2), .cyc_cnt(cyc_cnt2));

  // Tiny core model: PC advances on every enabled cycle, clears on core reset.
  always @(posedge clk) begin
    if (core_rst)     pc <= '0;
    else if (core_en) pc <= pc + 4'd1;
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one command for one edge; returns #1 into the following cycle.
  task automatic send(input logic [2:0] op, input logic [3:0] addr, input logic [7:0] data);
    hif.cmd_valid = 1'b1;
    hif.cmd_op    = op;
    hif.cmd_addr  = addr;
    hif.cmd_data  = data;
    @(posedge clk); #1;
    hif.cmd_valid = 1'b0;
    hif.cmd_op    = 3'd0;
  endtask

  task automatic step_test(input logic [7:0] n, input int exp_cycles);
    int cnt;
    logic rdy_seen;
    cnt = 0;
    rdy_seen = 1'b0;
    send(3'd4, 4'd0, n);
    while (core_en && cnt < 300) begin
      cnt++;
      rdy_seen |= hif.cmd_ready;
      @(posedge clk); #1;
    end
    chk($sformatf("step%0d_cycles", n), cnt, exp_cycles);
    chk($sformatf("step%0d_ready_low", n), {31'd0, rdy_seen}, 0);
    chk($sformatf("step%0d_halted", n), {31'd0, halted}, 1);
    chk($sformatf("step%0d_ready_back", n), {31'd0, hif.cmd_ready}, 1);
  endtask

  initial begin
    int k;
    hif.cmd_valid = 1'b0; hif.cmd_op = 3'd0; hif.cmd_addr = '0; hif.cmd_data = '0;
    hif2.cmd_valid = 1'b0; hif2.cmd_op = 3'd0; hif2.cmd_addr = '0; hif2.cmd_data = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_rst", {31'd0, core_rst}, 1);
    chk("rst_core_en", {31'd0, core_en}, 0);
    chk("rst_halted", {31'd0, halted}, 0);
    chk("rst_pm_we", {31'd0, pm_we}, 0);
    chk("rst_err", {31'd0, hif.cmd_err}, 0);
    chk("rst_bp_hit", {31'd0, bp_hit}, 0);
    chk("rst_cyc", {16'd0, cyc_cnt}, 0);
    rst = 1'b0;
    chk("rel_core_rst", {31'd0, core_rst}, 1);
    @(posedge clk); #1;
    chk("idle_core_rst", {31'd0, core_rst}, 0);
    chk("idle_halted", {31'd0, halted}, 1);
    chk("idle_core_en", {31'd0, core_en}, 0);
    chk("idle_cyc", {16'd0, cyc_cnt}, 0);
    chk("idle_ready", {31'd0, hif.cmd_ready}, 1);

    // program load
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      d = 8'hB0 | 8'(i);
      send(3'd1, 4'(i), d);
      chk($sformatf("wr%0d_we", i), {31'd0, pm_we}, 1);
      chk($sformatf("wr%0d_addr", i), {28'd0, pm_addr}, i);
      chk($sformatf("wr%0d_data", i), {24'd0, pm_wdata}, {24'd0, d});
      @(posedge clk); #1;
      chk($sformatf("wr%0d_we_off", i), {31'd0, pm_we}, 0);
    end

    // single-step
    step_test(8'd0, 1);
    step_test(8'd3, 3);
    step_test(8'd255, 255);
    chk("step_cyc", {16'd0, cyc_cnt}, 259);

    // run, refused write, repeated RUN, halt
    send(3'd2, 4'd0, 8'd0);
    chk("run_core_en", {31'd0, core_en}, 1);
    chk("run_halted", {31'd0, halted}, 0);
    send(3'd1, 4'd2, 8'h55);
    chk("runwr_we", {31'd0, pm_we}, 0);
    chk("runwr_err", {31'd0, hif.cmd_err}, 1);
    @(posedge clk); #1;
    chk("runwr_err_off", {31'd0, hif.cmd_err}, 0);
    send(3'd4, 4'd0, 8'd2);
    chk("runstep_err", {31'd0, hif.cmd_err}, 1);
    chk("runstep_en", {31'd0, core_en}, 1);
    send(3'd2, 4'd0, 8'd0);
    chk("runrun_err", {31'd0, hif.cmd_err}, 0);
    chk("runrun_en", {31'd0, core_en}, 1);
    send(3'd3, 4'd0, 8'd0);
    chk("halt_halted", {31'd0, halted}, 1);
    chk("halt_core_en", {31'd0, core_en}, 0);

    // reset core from HALT so the PC model restarts at 0
    send(3'd7, 4'd0, 8'd0);
    chk("rstc_core_rst", {31'd0, core_rst}, 1);
    @(posedge clk); #1;
    chk("rstc_pc", {28'd0, pc}, 0);
    chk("rstc_cyc", {16'd0, cyc_cnt}, 0);

    // breakpoint at PC 5
    send(3'd5, 4'd5, 8'd0);
    chk("setbp_err", {31'd0, hif.cmd_err}, 0);
    send(3'd2, 4'd0, 8'd0);
    k = 0;
    while (pc != 4'd5 && k < 40) begin
      k++;
      @(posedge clk); #1;
    end
    chk("bp_reach_pc5", {28'd0, pc}, 5);
`ifdef CPU_CTRL_BP_EN
    chk("bp_core_en", {31'd0, core_en}, 0);
    @(posedge clk); #1;
    chk("bp_halted", {31'd0, halted}, 1);
    chk("bp_hit", {31'd0, bp_hit}, 1);
    chk("bp_pc_held", {28'd0, pc}, 5);
    send(3'd2, 4'd0, 8'd0);
    chk("rerun_pc", {28'd0, pc}, 5);
    chk("rerun_core_en", {31'd0, core_en}, 1);
    @(posedge clk); #1;
    chk("rerun_pc6", {28'd0, pc}, 6);
    chk("rerun_not_halted", {31'd0, halted}, 0);
    chk("rerun_bp_sticky", {31'd0, bp_hit}, 1);
`else
    chk("nobp_core_en", {31'd0, core_en}, 1);
    @(posedge clk); #1;
    chk("nobp_halted", {31'd0, halted}, 0);
    chk("nobp_bp_hit", {31'd0, bp_hit}, 0);
`endif
    send(3'd3, 4'd0, 8'd0);
    send(3'd6, 4'd0, 8'd0);
    chk("clrbp_err", {31'd0, hif.cmd_err}, 0);

    // RSTCORE mid-run
    send(3'd2, 4'd0, 8'd0);
    repeat (9) @(posedge clk);
    #1;
    send(3'd7, 4'd0, 8'd0);
    chk("rstrun_core_en", {31'd0, core_en}, 0);
    chk("rstrun_core_rst", {31'd0, core_rst}, 1);
    @(posedge clk); #1;
    chk("rstrun_core_rst_off", {31'd0, core_rst}, 0);
    chk("rstrun_halted", {31'd0, halted}, 1);
    chk("rstrun_cyc", {16'd0, cyc_cnt}, 0);
    chk("rstrun_bp_hit", {31'd0, bp_hit}, 0);

    // saturation on the 4-bit counter instance
    hif2.cmd_valid = 1'b1;
    hif2.cmd_op    = 3'd2;
    @(posedge clk); #1;
    hif2.cmd_valid = 1'b0;
    hif2.cmd_op    = 3'd0;
    chk("sat_start", {28'd0, cyc_cnt2}, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("sat_mid", {28'd0, cyc_cnt2}, 5);
    repeat (15) @(posedge clk);
    #1;
    chk("sat_cap", {28'd0, cyc_cnt2}, 15);
    chk("sat_still_run", {31'd0, core_en2}, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
